// File: rtl/timer_pkg.sv
// Shared types and control-bit positions for the two-channel timer/counter.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_e;

  // Bit positions within a channel control word, shared with the register block.
  localparam int unsigned EN       = 0;
  localparam int unsigned RELOAD   = 1;
  localparam int unsigned COUNT_UP = 2;
  localparam int unsigned SRC      = 3;

endpackage

// File: rtl/timer_channel.sv
// Single counter channel: enable-edge load, tick-driven up/down count,
// hit detection with reload or one-shot completion, registered match pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_BW_p = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                reload,
  input  logic                count_up,
  input  logic [CNT_BW_p-1:0] load_value,
  input  logic [CNT_BW_p-1:0] compare_value,
  input  logic                tick,
  output logic [CNT_BW_p-1:0] value,
  output logic                hit,
  output logic                match,
  output logic                done,
  output logic                run
);

  logic                en_prev_r;
  cnt_state_e          state_r;
  logic [CNT_BW_p-1:0] value_r;
  logic                match_r;
  logic                done_r;

  logic                start_s;
  logic                run_s;
  logic                hit_s;
  logic [CNT_BW_p-1:0] next_value_s;

  // Edge detect, run qualification, hit and next count value.
  always_comb begin
    start_s = en & ~en_prev_r;
    run_s   = en & (state_r == RUN) & ~start_s;
    hit_s   = run_s & tick & (value_r == compare_value);
    if (count_up) begin
      next_value_s = value_r + {{(CNT_BW_p-1){1'b0}}, 1'b1};
    end else begin
      next_value_s = value_r - {{(CNT_BW_p-1){1'b0}}, 1'b1};
    end
  end

  // Channel state, count value, done flag and match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev_r <= 1'b0;
      state_r   <= IDLE;
      value_r   <= {CNT_BW_p{1'b0}};
      match_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      en_prev_r <= en;
      match_r   <= hit_s;
      if (!en) begin
        state_r <= IDLE;
      end else if (start_s) begin
        state_r <= RUN;
        value_r <= load_value;
        done_r  <= 1'b0;
      end else if (hit_s) begin
        if (reload) begin
          value_r <= load_value;
        end else begin
          done_r  <= 1'b1;
          state_r <= DONE;
        end
      end else if (run_s && tick) begin
        value_r <= next_value_s;
      end
    end
  end

  assign value = value_r;
  assign hit   = hit_s;
  assign match = match_r;
  assign done  = done_r;
  assign run   = run_s;

endmodule

// File: rtl/timer_counter_ctrl.sv
// Two-channel counting engine: channel-0 prescaler, channel-1 clock/cascade
// source select and sticky per-channel interrupts.
module timer_counter_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CNT_BW_p   = 32,
  parameter int unsigned PRESCALE_p = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cnt0_en,
  input  logic                i_cnt0_reload,
  input  logic                i_cnt0_count_up,
  input  logic [CNT_BW_p-1:0] i_cnt0_load_value,
  input  logic [CNT_BW_p-1:0] i_cnt0_compare_value,
  input  logic                i_cnt1_en,
  input  logic                i_cnt1_reload,
  input  logic                i_cnt1_count_up,
  input  logic                i_cnt1_src,
  input  logic [CNT_BW_p-1:0] i_cnt1_load_value,
  input  logic [CNT_BW_p-1:0] i_cnt1_compare_value,
  input  logic [1:0]          i_irq_clr,
  output logic [CNT_BW_p-1:0] o_cnt0_value,
  output logic [CNT_BW_p-1:0] o_cnt1_value,
  output logic                o_cnt0_match,
  output logic                o_cnt1_match,
  output logic                o_cnt0_done,
  output logic                o_cnt1_done,
  output logic [1:0]          o_irq
);

  localparam int unsigned PSC_W = (PRESCALE_p > 1) ? $clog2(PRESCALE_p) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE_p - 1);

  logic [PSC_W-1:0] presc_r;
  logic [1:0]       irq_r;

  logic tick0_s;
  logic tick1_s;
  logic hit0_s;
  logic hit1_s;
  logic run0_s;
  logic run1_s;

  // Channel tick generation: prescaled clock for ch0, clock or ch0 hit for ch1.
  always_comb begin
    tick0_s = (presc_r == PSC_LAST);
    if (i_cnt1_src) begin
      tick1_s = hit0_s;
    end else begin
      tick1_s = run1_s;
    end
  end

  // Prescaler idles at 0 outside RUN, so every enable edge restarts it cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PSC_W{1'b0}};
    end else if (run0_s && !tick0_s) begin
      presc_r <= presc_r + {{(PSC_W-1){1'b0}}, 1'b1};
    end else begin
      presc_r <= {PSC_W{1'b0}};
    end
  end

  // Sticky interrupts; a hit outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 2'b00;
    end else begin
      irq_r <= {hit1_s, hit0_s} | (irq_r & ~i_irq_clr);
    end
  end

  timer_channel #(.CNT_BW_p(CNT_BW_p)) u_ch0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (i_cnt0_en),
    .reload        (i_cnt0_reload),
    .count_up      (i_cnt0_count_up),
    .load_value    (i_cnt0_load_value),
    .compare_value (i_cnt0_compare_value),
    .tick          (tick0_s),
    .value         (o_cnt0_value),
    .hit           (hit0_s),
    .match         (o_cnt0_match),
    .done          (o_cnt0_done),
    .run           (run0_s)
  );

  timer_channel #(.CNT_BW_p(CNT_BW_p)) u_ch1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (i_cnt1_en),
    .reload        (i_cnt1_reload),
    .count_up      (i_cnt1_count_up),
    .load_value    (i_cnt1_load_value),
    .compare_value (i_cnt1_compare_value),
    .tick          (tick1_s),
    .value         (o_cnt1_value),
    .hit           (hit1_s),
    .match         (o_cnt1_match),
    .done          (o_cnt1_done),
    .run           (run1_s)
  );

  assign o_irq = irq_r;

endmodule

// File: doc/timer_counter_ctrl.md
Name: timer_counter_ctrl

Overview:
- Counting engine for the two timer/counter channels configured by the AXI4-Lite timer register block.
- Takes the per-channel enable, reload, direction, load and compare fields, plus the channel-1 source select.
- Sequences both counters and produces match pulses, one-shot done flags, sticky interrupts and live count values.
- Channel 1 either counts clocks or cascades off channel-0 matches.

Parameters:
- CNT_BW_p, 32: counter, load and compare width.
- PRESCALE_p, 1: channel-0 tick divider (tick every PRESCALE_p clocks); must be >=1, 1 = every clock.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_cnt0_en  in  1  channel 0 enable (level).
- i_cnt0_reload  in  1  1 = auto-reload on match, 0 = one-shot.
- i_cnt0_count_up  in  1  1 = increment, 0 = decrement.
- i_cnt0_load_value  in  CNT_BW_p  start/reload value.
- i_cnt0_compare_value  in  CNT_BW_p  match value.
- i_cnt1_en, i_cnt1_reload, i_cnt1_count_up  in  1 each  as for channel 0.
- i_cnt1_src  in  1  0 = tick every clock, 1 = tick on channel-0 hit.
- i_cnt1_load_value, i_cnt1_compare_value  in  CNT_BW_p  as for channel 0.
- i_irq_clr  in  2  per-channel interrupt clear pulse, bit n = channel n.
- o_cnt0_value, o_cnt1_value  out  CNT_BW_p  current count.
- o_cnt0_match, o_cnt1_match  out  1  one-cycle match pulse.
- o_cnt0_done, o_cnt1_done  out  1  one-shot completed (level).
- o_irq  out  2  sticky interrupt per channel.

Behaviour:
- Reset (async assert, sync release): all values 0, match 0, done 0, irq 0, prescaler 0, stored previous-enable bits 0.
- Enable rising edge is detected against the registered previous enable.
  - On the edge: value <= load_value, done <= 0, prescaler <= 0.
  - No tick is taken in the edge cycle.
- Channel state per counter: IDLE (en=0), RUN (en=1, done=0), DONE (en=1, done=1).
  - Any state -> IDLE when en=0; value holds.
  - IDLE -> RUN on an enable rising edge.
  - RUN -> DONE on a one-shot hit.
  - DONE -> RUN only via en 0->1.
- Hit = RUN & tick & (value == compare_value), evaluated combinationally in the tick cycle.
  - Hit with reload=1: value <= load_value.
  - Hit with reload=0: value holds, done <= 1.
  - No hit on a tick: value <= value +/- 1, wrapping modulo 2^CNT_BW_p (0xFFFFFFFF+1 = 0, 0-1 = 0xFFFFFFFF). Wrap itself raises no event.
- Match output is registered: o_cntN_match = 1 in the cycle after the hit edge, for exactly one cycle.
- Channel-0 tick: prescaler counts 0..PRESCALE_p-1 while RUN; tick when the prescaler = PRESCALE_p-1, then the prescaler wraps to 0.
- Channel-1 tick:
  - src=0: every clock while RUN.
  - src=1: the same-cycle combinational channel-0 hit. Channel 1 advances on the same edge that registers o_cnt0_match.
- Interrupts: irq[n] <= 1 on hit n; irq[n] <= 0 on i_irq_clr[n]. Hit and clear in the same cycle: set wins.
- Compare value changes apply on the next comparison. Load value changes apply only at the next enable edge or reload.
- A direction change mid-run applies to the next tick.
- No latency other than the one registered cycle; no backpressure.

Decomposition:
- Shared package timer_pkg: typedef cnt_state_e {IDLE, RUN, DONE}, and the control-bit positions EN=0, RELOAD=1, COUNT_UP=2, SRC=3 that the register block also uses.
- One sub-module, timer_channel: a single counter with en/reload/dir/load/compare/tick in and value/hit/match/done out.
  - Instantiated twice.
  - The top holds the prescaler, the cascade mux and the irq registers.

Test Plan:
- Up one-shot: load=5, cmp=8, up, reload=0, en=1 -> values 5,6,7,8; match pulses once 1 cycle after value=8 is seen; done=1; value stays 8; irq[0]=1.
- Down auto-reload: load=3, cmp=0, down, reload=1 -> sequence 3,2,1,0,3,2,...; a match every 4 cycles; done stays 0.
- Wrap: load=0xFFFFFFFE, cmp=1, up -> values FFFFFFFE, FFFFFFFF, 0, 1, then match. Down from 1 with cmp=0xFFFFFFFF -> 1, 0, FFFFFFFF, then match.
- Cascade: cnt0 load=0, cmp=2, reload=1; cnt1 src=1, load=0, cmp=3, up -> cnt1 increments every 3 clocks, on the same edge as each cnt0 hit; cnt1 match on the 4th cnt0 hit.
- Irq race: assert i_irq_clr[0] in the hit cycle -> irq[0] stays 1; a clear in a later cycle -> 0.
- Mid-run control: disable at value=6 -> holds 6. Re-enable -> reloads load value. Async rst_n pulse mid-count -> all outputs 0 immediately.
